mul8_nibble_seq: RTL

//  Sequential 8x8 unsigned multiplier with an optional accumulator.

---
 rtl/mul8_nibble_seq_if.sv | 31 +++
 rtl/mul8_nibble_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mul8_nibble_seq_if.sv
// Operand/result handshake bundle for mul8_nibble_seq.
//   in_valid/in_ready  : operand handshake, in_a/in_b/in_acc sampled at accept
//   acc_clr            : synchronous accumulator clear
//   out_valid/out_ready: result handshake, out_prod/out_acc/acc_ovf/busy status
// master = operand source / result sink side, slave = multiplier side.
interface mul8_nibble_seq_if #(
    parameter int unsigned ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_prod;
    logic [ACC_W-1:0] out_acc;
    logic             acc_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_prod, out_acc, acc_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_prod, out_acc, acc_ovf, busy
    );
endinterface

// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiplier with optional accumulator.
// Each operand is split into nibbles; one 4x4 partial product per cycle is
// shifted and summed into a 16-bit product, optionally added into an
// ACC_W-bit accumulator (saturating or wrapping).
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous, active-high reset
//   io_bus : mul8_nibble_seq_if.slave (operand/result handshakes, status)

// Exact 4x4 unsigned multiplier core (combinational).
module mul8_nibble_core (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p_c
);
    assign o_p_c = 8'(i_a) * 8'(i_b);
endmodule

module mul8_nibble_seq #(
    parameter int unsigned ACC_W = 24,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mul8_nibble_seq_if.slave io_bus
);
    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic                r_acc_en;
    logic [1:0]          r_cnt;
    logic [PROD_W-1:0]   r_prod;
    logic [PROD_W-1:0]   r_out_prod;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;
    logic                w_accept;
    logic                w_last;
    logic [NIB_W-1:0]    w_core_a;
    logic [NIB_W-1:0]    w_core_b;
    logic [2*NIB_W-1:0]  w_core_p;
    logic [PROD_W-1:0]   w_step;
    logic [PROD_W-1:0]   w_prod_next;
    logic [SUM_W-1:0]    w_sum;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MUL;
            S_MUL:   if (r_cnt == 2'd3) w_state_next = S_HOLD;
            S_HOLD:  if (io_bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; in_ready is also masked by reset.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~rst;
                w_busy     = 1'b0;
            end
            S_HOLD:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = io_bus.in_valid & w_in_ready;
    assign w_last   = (r_state == S_MUL) && (r_cnt == 2'd3);

    // cnt[0] picks the a nibble, cnt[1] the b nibble.
    assign w_core_a = r_cnt[0] ? r_a[7:4] : r_a[3:0];
    assign w_core_b = r_cnt[1] ? r_b[7:4] : r_b[3:0];

    mul8_nibble_core u_core (
        .i_a   (w_core_a),
        .i_b   (w_core_b),
        .o_p_c (w_core_p)
    );

    // Weight of the partial product: nibble-index sum times four bits.
    always_comb begin
        w_step = PROD_W'(w_core_p);
        case (r_cnt)
            2'd1, 2'd2: w_step = PROD_W'(w_core_p) << 4;
            2'd3:       w_step = PROD_W'(w_core_p) << 8;
            default:    ;
        endcase
    end

    assign w_prod_next = r_prod + w_step;
    assign w_sum       = SUM_W'(r_acc) + SUM_W'(w_prod_next);

    // Operand latch and partial-product accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_acc_en   <= 1'b0;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_out_prod <= '0;
        end else if (w_accept) begin
            r_a      <= io_bus.in_a;
            r_b      <= io_bus.in_b;
            r_acc_en <= io_bus.in_acc;
            r_cnt    <= '0;
            r_prod   <= '0;
        end else if (r_state == S_MUL) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + 2'd1;
            if (w_last) begin
                r_out_prod <= w_prod_next;
            end
        end
    end

    // Accumulator: clear takes effect before a coincident add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (io_bus.acc_clr) begin
            r_acc <= (w_last && r_acc_en) ? ACC_W'(w_prod_next) : '0;
            r_ovf <= 1'b0;
        end else if (w_last && r_acc_en) begin
            if (w_sum[ACC_W]) begin
                r_acc <= SAT ? '1 : w_sum[ACC_W-1:0];
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.busy      = w_busy;
    assign io_bus.out_prod  = r_out_prod;
    assign io_bus.out_acc   = r_acc;
    assign io_bus.acc_ovf   = r_ovf;
endmodule
